// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller: FSM states,
// instruction class/function codes and datapath select encodings.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_SHIFT,
      S_ALU_WB,
      S_MEM_ADR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_BRANCH
   } state_t;

   // instr[4:3] class
   localparam logic [1:0] CLS_DP_REG = 2'b00;
   localparam logic [1:0] CLS_DP_IMM = 2'b01;
   localparam logic [1:0] CLS_MEM    = 2'b10;
   localparam logic [1:0] CLS_BRANCH = 2'b11;

   // instr[2:0] data-processing function
   localparam logic [2:0] FN_AND   = 3'b000;
   localparam logic [2:0] FN_OR    = 3'b001;
   localparam logic [2:0] FN_ADD   = 3'b010;
   localparam logic [2:0] FN_SUB   = 3'b011;
   localparam logic [2:0] FN_CMP   = 3'b100;
   localparam logic [2:0] FN_MOV   = 3'b101;
   localparam logic [2:0] FN_SHIFT = 3'b110;
   localparam logic [2:0] FN_NOP   = 3'b111;

   // instr[2:0] branch condition
   localparam logic [2:0] BR_AL = 3'b000;
   localparam logic [2:0] BR_EQ = 3'b001;
   localparam logic [2:0] BR_NE = 3'b010;
   localparam logic [2:0] BR_L  = 3'b011;

   // alu_control
   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_OR    = 3'b011;
   localparam logic [2:0] ALU_PASSB = 3'b100;

   // alu_srcB
   localparam logic [1:0] SRCB_REG = 2'b00;
   localparam logic [1:0] SRCB_IMM = 2'b01;
   localparam logic [1:0] SRCB_ONE = 2'b10;

   // result_src
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;
   localparam logic [1:0] RES_SHIFT  = 2'b11;

   // imm_src
   localparam logic [1:0] IMM_DP  = 2'b00;
   localparam logic [1:0] IMM_MEM = 2'b01;
   localparam logic [1:0] IMM_BR  = 2'b10;

   // RegSrc
   localparam logic [3:0] REGSRC_STORE = 4'b0010;
   localparam logic [3:0] REGSRC_LINK  = 4'b1100;

   typedef struct packed {
      logic       adr_source;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       alu_src_a;
      logic       pc_write;
      logic [2:0] alu_control;
      logic [1:0] alu_src_b;
      logic [1:0] imm_src;
      logic [3:0] reg_src;
      logic [1:0] result_src;
      logic [2:0] shft_op;
   } ctrl_t;

   function automatic logic [2:0] dp_alu_op(input logic [2:0] fn);
      case (fn)
         FN_AND:         return ALU_AND;
         FN_OR:          return ALU_OR;
         FN_SUB, FN_CMP: return ALU_SUB;
         FN_MOV:         return ALU_PASSB;
         default:        return ALU_ADD;
      endcase
   endfunction

   function automatic logic [1:0] imm_for_class(input logic [1:0] cls);
      case (cls)
         CLS_MEM:    return IMM_MEM;
         CLS_BRANCH: return IMM_BR;
         default:    return IMM_DP;
      endcase
   endfunction

endpackage

// File: rtl/multi_cycle_control_unit_cond_check.sv
// Branch condition evaluation from instr[2:0] and the registered NZCV flags.
module cond_check
   import cpu_ctrl_pkg::*;
(
   input  logic [2:0] cond,
   input  logic [3:0] flags,
   output logic       taken
);

   // Z is flags[2]; codes 1xx never branch
   always_comb begin
      taken = 1'b0;
      case (cond)
         BR_AL, BR_L: taken = 1'b1;
         BR_EQ:       taken = flags[2];
         BR_NE:       taken = ~flags[2];
         default:     taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle CPU controller: Moore FSM with registered datapath controls
// and the architectural NZCV flag register.
module multi_cycle_control_unit
   import cpu_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       RESET,
   input  logic       RUN,
   input  logic [4:0] instr,
   input  logic [2:0] inst3,
   input  logic [3:0] alu_flags,
   output logic       adr_source,
   output logic       mem_Write,
   output logic       ir_Write,
   output logic       reg_Write,
   output logic       alu_srcA,
   output logic       pc_Write,
   output logic [2:0] alu_control,
   output logic [1:0] alu_srcB,
   output logic [1:0] imm_src,
   output logic [3:0] RegSrc,
   output logic [1:0] result_src,
   output logic [2:0] shft_op,
   output logic [3:0] ALU_flags
);

   state_t     state, state_nxt;
   ctrl_t      ctrl, ctrl_nxt;
   logic       flag_load;
   logic       br_taken;
   logic       boundary_go;
   logic [1:0] cls;
   logic [2:0] fn;

   assign cls = instr[4:3];
   assign fn  = instr[2:0];

   // RUN only matters where an instruction ends and the next would be fetched
   assign boundary_go = RUN;

   cond_check u_cond_check (
      .cond  (fn),
      .flags (ALU_flags),
      .taken (br_taken)
   );

   // Next-state selection and flag-capture strobe
   always_comb begin
      state_nxt = state;
      flag_load = 1'b0;
      case (state)
         S_IDLE:   state_nxt = RUN ? S_FETCH : S_IDLE;
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: begin
            case (cls)
               CLS_DP_REG: state_nxt = (fn == FN_SHIFT) ? S_SHIFT : S_EXEC_R;
               CLS_DP_IMM: state_nxt = S_EXEC_I;
               CLS_MEM:    state_nxt = S_MEM_ADR;
               default:    state_nxt = S_BRANCH;
            endcase
         end
         // Flags are latched at the end of execute; for ALU ops this is the
         // value the write-back cycle commits.
         S_EXEC_R, S_EXEC_I: begin
            flag_load = (fn != FN_NOP);
            if ((fn == FN_CMP) || (fn == FN_NOP))
               state_nxt = boundary_go ? S_FETCH : S_IDLE;
            else
               state_nxt = S_ALU_WB;
         end
         S_SHIFT: begin
            flag_load = 1'b1;
            state_nxt = boundary_go ? S_FETCH : S_IDLE;
         end
         S_MEM_ADR: state_nxt = instr[0] ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:  state_nxt = S_MEM_WB;
         S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH:
            state_nxt = boundary_go ? S_FETCH : S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Controls for the state being entered, so outputs register cleanly
   always_comb begin
      ctrl_nxt = '0;
      case (state_nxt)
         S_FETCH: begin
            ctrl_nxt.ir_write    = 1'b1;
            ctrl_nxt.alu_src_a   = 1'b1;
            ctrl_nxt.alu_src_b   = SRCB_ONE;
            ctrl_nxt.alu_control = ALU_ADD;
            ctrl_nxt.result_src  = RES_ALU;
            ctrl_nxt.pc_write    = 1'b1;
         end
         S_DECODE: ctrl_nxt.imm_src = imm_for_class(cls);
         S_EXEC_R: begin
            ctrl_nxt.alu_control = dp_alu_op(fn);
            ctrl_nxt.alu_src_b   = SRCB_REG;
         end
         S_EXEC_I: begin
            ctrl_nxt.alu_control = dp_alu_op(fn);
            ctrl_nxt.alu_src_b   = SRCB_IMM;
            ctrl_nxt.imm_src     = IMM_DP;
         end
         S_SHIFT: begin
            ctrl_nxt.shft_op    = inst3;
            ctrl_nxt.result_src = RES_SHIFT;
            ctrl_nxt.reg_write  = 1'b1;
         end
         S_ALU_WB: begin
            ctrl_nxt.result_src = RES_ALUOUT;
            ctrl_nxt.reg_write  = 1'b1;
         end
         S_MEM_ADR: begin
            ctrl_nxt.alu_src_b   = SRCB_IMM;
            ctrl_nxt.imm_src     = IMM_MEM;
            ctrl_nxt.alu_control = ALU_ADD;
         end
         S_MEM_RD: ctrl_nxt.adr_source = 1'b1;
         S_MEM_WB: begin
            ctrl_nxt.result_src = RES_MEM;
            ctrl_nxt.reg_write  = 1'b1;
         end
         S_MEM_WR: begin
            ctrl_nxt.adr_source = 1'b1;
            ctrl_nxt.reg_src    = REGSRC_STORE;
            ctrl_nxt.mem_write  = 1'b1;
         end
         S_BRANCH: begin
            ctrl_nxt.alu_src_a   = 1'b1;
            ctrl_nxt.alu_src_b   = SRCB_IMM;
            ctrl_nxt.imm_src     = IMM_BR;
            ctrl_nxt.alu_control = ALU_ADD;
            ctrl_nxt.result_src  = RES_ALU;
            ctrl_nxt.pc_write    = br_taken;
            if (fn == BR_L) begin
               ctrl_nxt.reg_write = 1'b1;
               ctrl_nxt.reg_src   = REGSRC_LINK;
            end
         end
         default: ctrl_nxt = '0;
      endcase
   end

   // State, registered controls and NZCV; reset clears all enables at once
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state     <= S_IDLE;
         ctrl      <= '0;
         ALU_flags <= '0;
      end else begin
         state <= state_nxt;
         ctrl  <= ctrl_nxt;
         if (flag_load)
            ALU_flags <= alu_flags;
      end
   end

   assign adr_source  = ctrl.adr_source;
   assign mem_Write   = ctrl.mem_write;
   assign ir_Write    = ctrl.ir_write;
   assign reg_Write   = ctrl.reg_write;
   assign alu_srcA    = ctrl.alu_src_a;
   assign pc_Write    = ctrl.pc_write;
   assign alu_control = ctrl.alu_control;
   assign alu_srcB    = ctrl.alu_src_b;
   assign imm_src     = ctrl.imm_src;
   assign RegSrc      = ctrl.reg_src;
   assign result_src  = ctrl.result_src;
   assign shft_op     = ctrl.shft_op;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Self-checking bench for multi_cycle_control_unit: directed table,
// hand sequences for RUN/RESET corners, and randomized instructions
// against a behavioural reference model.
module tb_multi_cycle_control_unit;

   logic       clk = 1'b0;
   logic       RESET;
   logic       RUN;
   logic [4:0] instr;
   logic [2:0] inst3;
   logic [3:0] alu_flags;
   logic       adr_source, mem_Write, ir_Write, reg_Write, alu_srcA, pc_Write;
   logic [2:0] alu_control;
   logic [1:0] alu_srcB, imm_src, result_src;
   logic [3:0] RegSrc;
   logic [2:0] shft_op;
   logic [3:0] ALU_flags;

   multi_cycle_control_unit dut (
      .clk         (clk),
      .RESET       (RESET),
      .RUN         (RUN),
      .instr       (instr),
      .inst3       (inst3),
      .alu_flags   (alu_flags),
      .adr_source  (adr_source),
      .mem_Write   (mem_Write),
      .ir_Write    (ir_Write),
      .reg_Write   (reg_Write),
      .alu_srcA    (alu_srcA),
      .pc_Write    (pc_Write),
      .alu_control (alu_control),
      .alu_srcB    (alu_srcB),
      .imm_src     (imm_src),
      .RegSrc      (RegSrc),
      .result_src  (result_src),
      .shft_op     (shft_op),
      .ALU_flags   (ALU_flags)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       adr_source;
      logic       mem_Write;
      logic       ir_Write;
      logic       reg_Write;
      logic       alu_srcA;
      logic       pc_Write;
      logic [2:0] alu_control;
      logic [1:0] alu_srcB;
      logic [1:0] imm_src;
      logic [3:0] RegSrc;
      logic [1:0] result_src;
      logic [2:0] shft_op;
   } outs_t;

   outs_t dut_o;
   assign dut_o = {adr_source, mem_Write, ir_Write, reg_Write, alu_srcA, pc_Write,
                   alu_control, alu_srcB, imm_src, RegSrc, result_src, shft_op};

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk_o(input string name, input outs_t act, input outs_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: outputs got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_n(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic outs_t ov(input logic adr, input logic memw, input logic irw,
                                input logic regw, input logic srca, input logic pcw,
                                input logic [2:0] aluc, input logic [1:0] srcb,
                                input logic [1:0] imm, input logic [3:0] rs,
                                input logic [1:0] res, input logic [2:0] sh);
      return {adr, memw, irw, regw, srca, pcw, aluc, srcb, imm, rs, res, sh};
   endfunction

   outs_t fetch_v;
   outs_t zero_v;

   // Reference model: expected outputs of every cycle after FETCH
   logic [2:0] dp_alu [0:7] = '{3'b010, 3'b011, 3'b000, 3'b001,
                                3'b001, 3'b100, 3'b000, 3'b000};
   logic [3:0] m_flags;
   outs_t      exp_q[$];

   task automatic build_model(input logic [4:0] ins, input logic [2:0] i3,
                              input logic [3:0] af);
      logic [1:0] cls;
      logic [2:0] fn;
      outs_t      v;
      bit         taken;
      cls = ins[4:3];
      fn  = ins[2:0];
      exp_q.delete();
      v = '0;
      v.imm_src = (cls == 2'd2) ? 2'b01 : (cls == 2'd3) ? 2'b10 : 2'b00;
      exp_q.push_back(v);
      if (cls == 2'd0 && fn == 3'd6) begin
         v = '0; v.shft_op = i3; v.result_src = 2'b11; v.reg_Write = 1'b1;
         exp_q.push_back(v);
         m_flags = af;
      end else if (cls < 2'd2) begin
         v = '0; v.alu_control = dp_alu[fn]; v.alu_srcB = (cls == 2'd0) ? 2'b00 : 2'b01;
         exp_q.push_back(v);
         if (fn != 3'd7) m_flags = af;
         if (fn != 3'd4 && fn != 3'd7) begin
            v = '0; v.reg_Write = 1'b1;
            exp_q.push_back(v);
         end
      end else if (cls == 2'd2) begin
         v = '0; v.alu_srcB = 2'b01; v.imm_src = 2'b01;
         exp_q.push_back(v);
         if (!fn[0]) begin
            v = '0; v.adr_source = 1'b1;
            exp_q.push_back(v);
            v = '0; v.result_src = 2'b01; v.reg_Write = 1'b1;
            exp_q.push_back(v);
         end else begin
            v = '0; v.adr_source = 1'b1; v.mem_Write = 1'b1; v.RegSrc = 4'b0010;
            exp_q.push_back(v);
         end
      end else begin
         taken = (fn == 3'd0) || (fn == 3'd3) ||
                 (fn == 3'd1 && m_flags[2]) || (fn == 3'd2 && !m_flags[2]);
         v = '0; v.alu_srcA = 1'b1; v.alu_srcB = 2'b01; v.imm_src = 2'b10;
         v.result_src = 2'b10; v.pc_Write = taken;
         if (fn == 3'd3) begin
            v.reg_Write = 1'b1; v.RegSrc = 4'b1100;
         end
         exp_q.push_back(v);
      end
   endtask

   typedef struct {
      logic [4:0] instr;
      logic [2:0] inst3;
      logic [3:0] af;
      int         cycles;
      logic [3:0] flags;
      outs_t      last;
      string      name;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      outs_t wb_v, br_t, br_n, bl_v, cmp_v, ldr_v, str_v, sh_v;
      int    cyc;
      int    found;
      outs_t last;

      fetch_v = ov(0,0,1,0,1,1,3'b000,2'b10,2'b00,4'b0000,2'b10,3'b000);
      zero_v  = '0;
      wb_v  = ov(0,0,0,1,0,0,3'b000,2'b00,2'b00,4'b0000,2'b00,3'b000);
      br_t  = ov(0,0,0,0,1,1,3'b000,2'b01,2'b10,4'b0000,2'b10,3'b000);
      br_n  = ov(0,0,0,0,1,0,3'b000,2'b01,2'b10,4'b0000,2'b10,3'b000);
      bl_v  = ov(0,0,0,1,1,1,3'b000,2'b01,2'b10,4'b1100,2'b10,3'b000);
      cmp_v = ov(0,0,0,0,0,0,3'b001,2'b00,2'b00,4'b0000,2'b00,3'b000);
      ldr_v = ov(0,0,0,1,0,0,3'b000,2'b00,2'b00,4'b0000,2'b01,3'b000);
      str_v = ov(1,1,0,0,0,0,3'b000,2'b00,2'b00,4'b0010,2'b00,3'b000);
      sh_v  = ov(0,0,0,1,0,0,3'b000,2'b00,2'b00,4'b0000,2'b11,3'b010);

      //             instr     inst3   alu_flags cyc flags    last   name
      tbl.push_back('{5'b00010, 3'b000, 4'b0100, 4, 4'b0100, wb_v,   "add_r"});
      tbl.push_back('{5'b11001, 3'b000, 4'b1111, 3, 4'b0100, br_t,   "beq_z1"});
      tbl.push_back('{5'b00100, 3'b000, 4'b1001, 3, 4'b1001, cmp_v,  "cmp"});
      tbl.push_back('{5'b11001, 3'b000, 4'b1111, 3, 4'b1001, br_n,   "beq_z0"});
      tbl.push_back('{5'b11010, 3'b000, 4'b1111, 3, 4'b1001, br_t,   "bne_z0"});
      tbl.push_back('{5'b10000, 3'b000, 4'b0110, 5, 4'b1001, ldr_v,  "ldr"});
      tbl.push_back('{5'b10001, 3'b000, 4'b0110, 4, 4'b1001, str_v,  "str"});
      tbl.push_back('{5'b11011, 3'b000, 4'b0110, 3, 4'b1001, bl_v,   "bl"});
      tbl.push_back('{5'b00110, 3'b010, 4'b0010, 3, 4'b0010, sh_v,   "shift"});
      tbl.push_back('{5'b01101, 3'b000, 4'b1000, 4, 4'b1000, wb_v,   "mov_i"});
      tbl.push_back('{5'b00111, 3'b000, 4'b0101, 3, 4'b1000, zero_v, "nop"});
      tbl.push_back('{5'b11100, 3'b000, 4'b0101, 3, 4'b1000, br_n,   "b_never"});
      tbl.push_back('{5'b01000, 3'b000, 4'b0001, 4, 4'b0001, wb_v,   "and_i"});

      RESET = 1'b0; RUN = 1'b0; instr = '0; inst3 = '0; alu_flags = '0;
      #3;
      chk_o("reset_outs", dut_o, zero_v);
      chk_n("reset_flags", int'(ALU_flags), 0);
      @(negedge clk);
      RESET = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk_o("idle_hold", dut_o, zero_v);
      end
      RUN = 1'b1;
      @(negedge clk);

      // Directed table: cycles until next FETCH, last-state controls, flags
      for (int i = 0; i < tbl.size(); i++) begin
         chk_o({tbl[i].name, "_fetch"}, dut_o, fetch_v);
         instr = tbl[i].instr; inst3 = tbl[i].inst3; alu_flags = tbl[i].af;
         cyc = 0;
         last = '0;
         for (int n = 1; n <= 10; n++) begin
            last = dut_o;
            @(negedge clk);
            if (ir_Write) begin
               cyc = n;
               break;
            end
         end
         chk_n({tbl[i].name, "_cycles"}, cyc, tbl[i].cycles);
         chk_o({tbl[i].name, "_last"}, last, tbl[i].last);
         chk_n({tbl[i].name, "_flags"}, int'(ALU_flags), int'(tbl[i].flags));
      end

      // RUN dropped during ALU_WB: instruction completes, then parks in IDLE
      chk_o("run_fetch", dut_o, fetch_v);
      instr = 5'b00010; alu_flags = 4'b0011;
      found = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (reg_Write && result_src == 2'b00) begin
            found = 1;
            break;
         end
      end
      chk_n("run_wb_reached", found, 1);
      RUN = 1'b0;
      @(negedge clk);
      chk_o("run_idle", dut_o, zero_v);
      chk_n("run_flags", int'(ALU_flags), 3);
      repeat (3) begin
         @(negedge clk);
         chk_o("run_park", dut_o, zero_v);
      end

      // RESET asserted in the middle of FETCH
      RUN = 1'b1;
      @(negedge clk);
      chk_o("restart_fetch", dut_o, fetch_v);
      RESET = 1'b0;
      #1;
      chk_o("midfetch_rst_outs", dut_o, zero_v);
      chk_n("midfetch_rst_flags", int'(ALU_flags), 0);
      @(negedge clk);
      chk_o("rst_held", dut_o, zero_v);
      RESET = 1'b1;
      @(negedge clk);

      // Randomized instructions against the reference model
      m_flags = 4'b0000;
      for (int k = 0; k < 300; k++) begin
         chk_o("rnd_fetch", dut_o, fetch_v);
         chk_n("rnd_flags", int'(ALU_flags), int'(m_flags));
         instr     = 5'($urandom);
         inst3     = 3'($urandom);
         alu_flags = 4'($urandom);
         build_model(instr, inst3, alu_flags);
         foreach (exp_q[j]) begin
            @(negedge clk);
            chk_o("rnd_step", dut_o, exp_q[j]);
         end
         @(negedge clk);
      end
      chk_o("rnd_end_fetch", dut_o, fetch_v);
      chk_n("rnd_end_flags", int'(ALU_flags), int'(m_flags));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
